amiga_clk_en_rst: RTL and testbench
===================================

// Module: amiga_clk_en_rst
// PURPOSE
//  Sits directly downstream of the MMCM clock generator, in the 28 MHz (c1) domain.
//  Turns the raw MMCM lock into a clean synchronous system reset (rst_out).
//  Derives the chipset timing enables from a phase counter: 7 MHz enables,
//  3.5 MHz c1/c3 quadrature and the E-clock.
//  Every consumer of the 28 MHz clock takes its reset and timing from this block.
// PARAMETERS
//  LOCK_SYNC_STAGES  2     synchroniser flops on pll_locked (>=2)
//  RST_HOLD_CYCLES   4096  clk cycles rst_out is held after synchronised lock (>=1)
// PORTS
//  clk         in   1  28 MHz clock (BUFG'd c1 of clock generator)
//  reset       in   1  synchronous, active-high reset
//  pll_locked  in   1  MMCM LOCKED, asynchronous to clk
//  rst_out     out  1  system reset, active-high, synchronous to clk
//  ready       out  1  1 while in RUN
//  clk7_en     out  1  one-cycle enable, 7 MHz rate (ph[1:0]==3)
//  clk7n_en    out  1  one-cycle enable, 7 MHz rate, 180 deg (ph[1:0]==1)
//  c1          out  1  3.5 MHz level = ph[2]
//  c3          out  1  3.5 MHz level = ph[2]^ph[1] (leads c1 by 90 deg)
//  eclk        out  1  E-clock level, high while e_cnt>=6 (6 of 10 clk7 periods low)
//  eclk_en     out  1  one-cycle pulse when clk7_en && e_cnt==9
// BEHAVIOUR
//  Lock synchronisation
//   - pll_locked passes through LOCK_SYNC_STAGES flops -> lock_s.
//   - Synchroniser flops clear on reset.
//  FSM (one-hot or binary), states WAIT_LOCK, HOLD, RUN
//   - reset=1 -> WAIT_LOCK next cycle, from any state (overrides everything).
//   - WAIT_LOCK: hold_cnt=0. lock_s=1 -> HOLD.
//   - HOLD: hold_cnt increments every cycle.
//     lock_s=0 -> WAIT_LOCK, hold_cnt cleared.
//     hold_cnt==RST_HOLD_CYCLES-1 -> RUN.
//   - RUN: lock_s=0 -> WAIT_LOCK in the same cycle it is seen; no other exit.
//   - Any lock loss, including a 1-cycle glitch after sync, restarts the full hold.
//  Counters
//   - hold_cnt width = $clog2(RST_HOLD_CYCLES+1), unsigned.
//   - ph[2:0]: 0 outside RUN; in RUN increments each cycle, wraps 7->0.
//   - e_cnt (0..9): 0 outside RUN; in RUN advances on clk7_en, wraps 9->0.
//  Outputs (all registered, no combinational paths from inputs)
//   - Reset values: rst_out=1, ready=0; clk7_en, clk7n_en, c1, c3, eclk, eclk_en=0.
//   - rst_out=1 and ready=0 in WAIT_LOCK and HOLD.
//   - rst_out=0 and ready=1 from the first RUN cycle.
//   - Enables are 0 outside RUN. First RUN cycle has ph=0.
//     First clk7n_en on RUN cycle 2, first clk7_en on RUN cycle 4.
//   - clk7_en and clk7n_en are never high in the same cycle.
//     Each is high exactly 1 of every 4 cycles.
//   - Leaving RUN: all enables and levels go 0 and rst_out goes 1 on the same edge.
//  Latency
//   - pll_locked rise to first RUN cycle = LOCK_SYNC_STAGES + RST_HOLD_CYCLES + 1
//     clk cycles (+/-1 for async sampling).
// TESTING
//  - Reset 3 cycles; pll_locked=1 constant, RST_HOLD_CYCLES=16
//    -> rst_out falls exactly 16+2+1 (+/-1) cycles after reset release; ready rises same edge.
//  - RUN for 80 cycles
//    -> clk7_en 20 pulses, clk7n_en 20 pulses, never coincident;
//       c1 period 8; c3 pattern 0,1,1,0 per 2-cycle step;
//       eclk_en exactly 2 pulses, spaced 40 cycles.
//  - pll_locked low 1 cycle mid-HOLD (hold_cnt=10)
//    -> back to WAIT_LOCK; full 16-cycle hold restarts; rst_out stays 1 throughout.
//  - pll_locked low 3 cycles in RUN
//    -> rst_out=1 and all enables 0 within LOCK_SYNC_STAGES+1 cycles;
//       after relock, rst_out=1 for a full hold, then ph restarts at 0.
//  - reset asserted 1 cycle in RUN with pll_locked=1
//    -> next edge rst_out=1, ready=0, e_cnt=0; RUN re-entered after full hold.
//  - pll_locked toggling every 5 cycles for 200 cycles
//    -> rst_out never deasserts, no enable pulse observed.

Source files
------------

// File: rtl/amiga_clk_en_rst.sv
// Reset sequencer and chipset timing enables for the 28 MHz domain.
// Holds rst_out until PLL lock has been stable, then runs the phase counters.
module amiga_clk_en_rst #(
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int RST_HOLD_CYCLES  = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic pll_locked,
  output logic rst_out,
  output logic ready,
  output logic clk7_en,
  output logic clk7n_en,
  output logic c1,
  output logic c3,
  output logic eclk,
  output logic eclk_en
);

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t state;
  logic [HW-1:0] hold_cnt;
  logic [LOCK_SYNC_STAGES-1:0] sync_q;
  logic lock_s;
  logic [2:0] ph;
  logic [2:0] ph_n;
  logic [3:0] e_cnt;
  logic [3:0] e_n;
  logic go_run;

  assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_locked};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_LOCK;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          hold_cnt <= '0;
          if (lock_s) state <= HOLD;
        end
        HOLD: begin
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
            if (hold_cnt == HOLD_LAST) state <= RUN;
          end
        end
        RUN: begin
          hold_cnt <= '0;
          if (!lock_s) state <= WAIT_LOCK;
        end
        default: begin
          state    <= WAIT_LOCK;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with state.
  always_comb begin
    go_run = !reset && lock_s &&
             (state == RUN ||
              (state == HOLD && hold_cnt == HOLD_LAST));
    ph_n = 3'd0;
    e_n  = 4'd0;
    if (go_run && state == RUN) begin
      ph_n = ph + 3'd1;
      e_n  = e_cnt;
      if (clk7_en) begin
        e_n = (e_cnt == 4'd9) ? 4'd0 : e_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph       <= 3'd0;
      e_cnt    <= 4'd0;
      rst_out  <= 1'b1;
      ready    <= 1'b0;
      clk7_en  <= 1'b0;
      clk7n_en <= 1'b0;
      c1       <= 1'b0;
      c3       <= 1'b0;
      eclk     <= 1'b0;
      eclk_en  <= 1'b0;
    end else begin
      ph       <= ph_n;
      e_cnt    <= e_n;
      rst_out  <= !go_run;
      ready    <= go_run;
      clk7_en  <= go_run && ph_n[1:0] == 2'd3;
      clk7n_en <= go_run && ph_n[1:0] == 2'd1;
      c1       <= go_run && ph_n[2];
      c3       <= go_run && (ph_n[2] ^ ph_n[1]);
      eclk     <= go_run && e_n >= 4'd6;
      eclk_en  <= go_run && ph_n[1:0] == 2'd3 && e_n == 4'd9;
    end
  end

endmodule

// File: tb/tb_amiga_clk_en_rst.sv
// Self-checking bench for amiga_clk_en_rst with a lock-streak reference model.
// Directed scenarios plus randomized lock/reset traffic.
module tb_amiga_clk_en_rst;

  localparam int HOLD = 16;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b1;
  logic rst_out, ready, clk7_en, clk7n_en, c1, c3, eclk, eclk_en;

  int n_cmp = 0;
  int n_bad = 0;

  amiga_clk_en_rst #(
    .LOCK_SYNC_STAGES(SYNC),
    .RST_HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_locked(pll_locked),
    .rst_out(rst_out),
    .ready(ready),
    .clk7_en(clk7_en),
    .clk7n_en(clk7n_en),
    .c1(c1),
    .c3(c3),
    .eclk(eclk),
    .eclk_en(eclk_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count consecutive edges with synchronised lock high; RUN once the
  // streak exceeds HOLD, and all timing is plain arithmetic on the run index.
  int streak = 0;
  bit pll_h1 = 0, pll_h2 = 0;
  bit rst_h1 = 1, rst_h2 = 1;

  always @(posedge clk) begin
    bit lk;
    bit run;
    int r, e;
    logic [8:0] exp_v, act_v;
    lk = pll_h2 && !rst_h2 && !rst_h1;
    if (reset) streak = 0;
    else if (lk) streak = streak + 1;
    else streak = 0;
    pll_h2 = pll_h1;
    pll_h1 = pll_locked;
    rst_h2 = rst_h1;
    rst_h1 = reset;
    run = streak >= HOLD + 1;
    r = run ? streak - (HOLD + 1) : 0;
    e = (r / 4) % 10;
    exp_v = {!run, run,
             run && (r % 4 == 3),
             run && (r % 4 == 1),
             run && (r % 8 >= 4),
             run && (r % 8 >= 2) && (r % 8 <= 5),
             run && (e >= 6),
             run && (r % 4 == 3) && (e == 9),
             1'b0};
    #1;
    act_v = {rst_out, ready, clk7_en, clk7n_en, c1, c3, eclk, eclk_en, 1'b0};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model: got %b expected %b (streak %0d) at %0t",
               act_v, exp_v, streak, $time);
    end
  end

  task automatic wait_fall(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (!rst_out) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_sched(input int a1, input int b1, input int a2,
                           input int b2, output int n_rise,
                           output int n_fall);
    n_rise = -1;
    n_fall = -1;
    for (int n = 1; n <= 200; n++) begin
      pll_locked = !((n >= a1 && n <= b1) || (n >= a2 && n <= b2));
      @(posedge clk);
      #1;
      if (rst_out && n_rise < 0) n_rise = n;
      if (!rst_out && n_rise > 0) begin
        n_fall = n;
        break;
      end
    end
    pll_locked = 1'b1;
  endtask

  initial begin
    int n, nr, nf;
    int k7, k7n, kco, ke, e_first, e_second;
    int rst_low, en_seen;
    logic [7:0] c1_pat, c3_pat;

    reset = 1'b1;
    pll_locked = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rst_out", rst_out, 1);
    check("reset_ready", ready, 0);
    check("reset_clk7_en", clk7_en, 0);
    reset = 1'b0;
    wait_fall(n);
    check("lock_latency", n, HOLD + SYNC + 1);
    check("ready_at_run", ready, 1);

    k7 = 0; k7n = 0; kco = 0; ke = 0;
    e_first = -1; e_second = -1;
    c1_pat = '0; c3_pat = '0;
    for (int r = 0; r < 80; r++) begin
      if (r > 0) begin
        @(posedge clk);
        #1;
      end
      k7 += int'(clk7_en);
      k7n += int'(clk7n_en);
      kco += int'(clk7_en && clk7n_en);
      if (eclk_en) begin
        ke++;
        if (e_first < 0) e_first = r;
        else e_second = r;
      end
      if (r < 8) begin
        c1_pat = {c1_pat[6:0], c1};
        c3_pat = {c3_pat[6:0], c3};
      end
    end
    check("clk7_count", k7, 20);
    check("clk7n_count", k7n, 20);
    check("coincident", kco, 0);
    check("eclk_en_count", ke, 2);
    check("eclk_en_first", e_first, 39);
    check("eclk_en_spacing", e_second - e_first, 40);
    check("c1_pattern", int'(c1_pat), 8'b0000_1111);
    check("c3_pattern", int'(c3_pat), 8'b0011_1100);

    // lock lost for three cycles while running
    run_sched(1, 3, 0, -1, nr, nf);
    check("loss_rst_rise", nr, SYNC + 1);
    check("relock_fall", nf, 3 + SYNC + HOLD + 1);
    check("relock_c1", c1, 0);

    // leave RUN, then a one-cycle glitch while hold_cnt is 10
    run_sched(1, 3, 15, 15, nr, nf);
    check("glitch_rst_rise", nr, SYNC + 1);
    check("glitch_fall", nf, 15 + SYNC + HOLD + 1);

    // one-cycle reset while running
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_run_rst_out", rst_out, 1);
    check("rst_in_run_ready", ready, 0);
    check("rst_in_run_eclk", eclk, 0);
    reset = 1'b0;
    wait_fall(n);
    check("rst_in_run_relatch", n, HOLD + SYNC + 1);

    // lock toggling every 5 cycles never reaches RUN
    rst_low = 0;
    en_seen = 0;
    for (int i = 0; i < 200; i++) begin
      pll_locked = ((i / 5) % 2) == 1;
      @(posedge clk);
      #1;
      if (i >= 4) begin
        rst_low += int'(!rst_out);
        en_seen += int'(clk7_en || clk7n_en || eclk_en);
      end
    end
    check("toggle_rst_low", rst_low, 0);
    check("toggle_enables", en_seen, 0);

    // randomized lock dropouts and resets, checked by the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      pll_locked = ($urandom_range(0, 59) != 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    pll_locked = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
